// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB with a memory-ready stall.
// Optional performance counters are built when CTRL_PERF_COUNTERS_EN is defined.
module mips_multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        BranchTaken,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic        Illegal,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state_r;
  state_t     state_next_s;
  logic [5:0] opcode_r;
  logic [5:0] funct_r;

  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          default:                               ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    logic [3:0] alu;
    case (fn)
      FN_ADD:  alu = ALU_ADD;
      FN_SUB:  alu = ALU_SUB;
      FN_AND:  alu = ALU_AND;
      FN_OR:   alu = ALU_OR;
      FN_SLT:  alu = ALU_SLT;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction fields are frozen in DECODE so later states ignore IR changes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_r <= 6'd0;
      funct_r  <= 6'd0;
    end else if (state_r == S_DECODE) begin
      opcode_r <= Opcode;
      funct_r  <= Funct;
    end else begin
      opcode_r <= opcode_r;
      funct_r  <= funct_r;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_next_s = state_r;
    PCWrite      = 1'b0;
    BranchTaken  = 1'b0;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    ALUSrcB      = 1'b0;
    ALUControl   = 4'b0000;
    Illegal      = 1'b0;
    case (state_r)
      S_IDLE: state_next_s = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      // Decode looks at the live IR fields; the captured copy is not loaded yet
      S_DECODE: begin
        if (instr_legal(Opcode, Funct)) begin
          state_next_s = S_EXEC;
        end else begin
          Illegal      = 1'b1;
          state_next_s = S_FETCH;
        end
      end
      S_EXEC: begin
        case (opcode_r)
          OP_R: begin
            ALUControl   = r_alu(funct_r);
            state_next_s = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrcB      = 1'b1;
            ALUControl   = ALU_ADD;
            state_next_s = S_MEM;
          end
          OP_ADDI: begin
            ALUSrcB      = 1'b1;
            ALUControl   = ALU_ADD;
            state_next_s = S_WB;
          end
          OP_BEQ: begin
            ALUControl   = ALU_SUB;
            BranchTaken  = Zero;
            state_next_s = S_FETCH;
          end
          default: state_next_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (opcode_r == OP_SW) begin
          MemWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (MemReady) begin
          state_next_s = (opcode_r == OP_SW) ? S_FETCH : S_WB;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (opcode_r == OP_R) begin
          RegDst = 1'b1;
        end else if (opcode_r == OP_LW) begin
          MemToReg = 1'b1;
        end else begin
          RegDst = 1'b0;
        end
        state_next_s = S_FETCH;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count_r;
  logic [31:0] instr_count_r;
  logic        retire_s;

  // An instruction retires whenever the sequence returns to FETCH from a later state
  assign retire_s = (state_next_s == S_FETCH) && (state_r != S_IDLE) && (state_r != S_FETCH);

  // Free-running performance counters, wrapping modulo 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count_r <= 32'd0;
      instr_count_r <= 32'd0;
    end else begin
      cycle_count_r <= (state_r != S_IDLE) ? cycle_count_r + 32'd1 : cycle_count_r;
      instr_count_r <= retire_s ? instr_count_r + 32'd1 : instr_count_r;
    end
  end

  assign CycleCount = cycle_count_r;
  assign InstrCount = instr_count_r;
`else
  assign CycleCount = 32'h0;
  assign InstrCount = 32'h0;
`endif

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control unit for the MIPS CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath strobes: PC write, IR write, memory read/write, register write, ALU select and ALU control. It reads Opcode, Funct and Zero back from the datapath, and waits on a memory-ready handshake so that slow memories stall the sequence.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- Opcode  in  6  instruction[31:26] from the datapath IR
- Funct  in  6  instruction[5:0] from the datapath IR
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  load PC+4 into PC
- BranchTaken  out  1  load the branch target into PC
- IRWrite  out  1  latch memory dout into IR
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address select: 0 = PC, 1 = ALU out
- RegWrite  out  1  register file write enable
- RegDst  out  1  write address select: 0 = rt, 1 = rd
- MemToReg  out  1  write data select: 0 = ALU, 1 = memory
- ALUSrcB  out  1  ALU B input select: 0 = rdB, 1 = sign-extended imm
- ALUControl  out  4  ALU operation code
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- CycleCount  out  32  performance counter (see Configuration)
- InstrCount  out  32  retired-instruction counter (see Configuration)

Clock is `clock`, reset is `reset`. Reset is asynchronous and active-high.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB.

State transitions:
- IDLE: entered on reset; moves to FETCH on the first clock after reset deasserts.
- FETCH: drives MemRead=1, IorD=0.
  - While MemReady=1: IRWrite=1 and PCWrite=1; next state DECODE.
  - Otherwise the state holds and all strobes except MemRead stay 0.
- DECODE: captures Opcode/Funct into internal registers; all later states use the captured copy. Next state:
  - R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000) -> EXEC
  - any other opcode, or an R-type funct not in {100000, 100010, 100100, 100101, 101010} -> Illegal=1 for one cycle, then FETCH (the instruction executes as a NOP).
- EXEC:
  - ALUControl: add 0010, sub 0110, and 0000, or 0001, slt 0111.
  - lw, sw, addi: ALUSrcB=1, ALUControl=0010.
  - beq: ALUControl=0110, BranchTaken=Zero, then FETCH.
  - R-type, addi -> WB; lw, sw -> MEM.
- MEM: IorD=1; MemRead=1 for lw, MemWrite=1 for sw.
  - The request is held until MemReady=1.
  - Then lw -> WB, sw -> FETCH.
- WB: RegWrite=1, then FETCH.
  - R-type: RegDst=1, MemToReg=0.
  - addi: RegDst=0, MemToReg=0.
  - lw: RegDst=0, MemToReg=1.

Output rules:
- Outputs are a Moore decode of the state and the captured fields, plus MemReady/Zero where stated.
- Any output not listed for a state is 0.
- MemRead and MemWrite are never both 1.
- PCWrite and BranchTaken are never both 1.

## Timing
- Reset values: state IDLE; every output 0; counters 0. Reset may assert in any state, including mid-stall; the unit returns to IDLE immediately and no further strobe is issued.
- Instruction latency with MemReady always 1: beq 3, sw 4, R-type 4, addi 4, lw 5, illegal 2 cycles.
- Each cycle MemReady=0 in FETCH or MEM adds exactly one cycle.
- BranchTaken samples Zero combinationally in EXEC only.
- MemReady is ignored in DECODE, EXEC and WB.

## Configuration
- Macro: `CTRL_PERF_COUNTERS_EN`.
- Defined:
  - CycleCount increments every clock not in IDLE.
  - InstrCount increments on each transition into FETCH from DECODE (illegal), EXEC (beq), MEM (sw) or WB.
  - Both counters wrap modulo 2^32.
- Undefined: both ports are tied to 32'h0 and no counter registers are built.

## Test plan
- Reset release, MemReady=1, IR = add (000000/100000): IDLE -> FETCH -> DECODE -> EXEC (ALUControl=0010) -> WB (RegWrite=1, RegDst=1) -> FETCH; PCWrite pulses exactly once.
- lw with MemReady low for 3 cycles in MEM: MemRead=1 and IorD=1 held for 4 cycles; WB has MemToReg=1, RegDst=0; total 8 cycles.
- beq with Zero=1: BranchTaken=1 in EXEC, PCWrite=0; beq with Zero=0: BranchTaken=0; each takes 3 cycles.
- Opcode 111111, then R-type funct 000111: Illegal pulses once for each, with no RegWrite and no MemWrite; both return to FETCH after 2 cycles.
- Reset asserted during a sw MEM stall: MemWrite drops to 0 asynchronously and the state is IDLE; after release the next state is FETCH.
- With CTRL_PERF_COUNTERS_EN, running add, lw, sw, beq back-to-back with MemReady=1: InstrCount=4 and CycleCount=16 (1 cycle in IDLE not counted); without the macro both read 0.
